rr_fifo_dispatcher: RTL and testbench

Single-stream to four-lane round-robin dispatcher: the write-side counterpart of the four-FIFO round-robin arbiter. One producer pushes bytes through a valid/ready port. Bytes are distributed in strict rotation to four 8-deep lane FIFOs. Four independent consumers drain their lanes with per-lane read enables, and each lane reports a registered data output, a valid flag and an error flag.

---
 rtl/rr_dispatch_pkg.sv | 9 +
 rtl/rr_fifo_dispatcher_if.sv | 25 ++
 rtl/dispatch_lane_fifo.sv | 82 ++++++++
 rtl/rr_fifo_dispatcher.sv | 88 ++++++++
 tb/tb_rr_fifo_dispatcher.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_dispatch_pkg.sv
// rtl/rr_dispatch_pkg.sv - shared constants and types for the round-robin FIFO dispatcher
package rr_dispatch_pkg;
    localparam int LANES         = 4;
    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [1:0]                       lane_idx_t;
    typedef logic [$clog2(DEFAULT_DEPTH):0]   lane_count_t;
endpackage

// File: rtl/rr_fifo_dispatcher_if.sv
// rtl/rr_fifo_dispatcher_if.sv - producer stream, per-lane read and status signals of the dispatcher
interface rr_fifo_dispatcher_if
    import rr_dispatch_pkg::*;
#(
    parameter int DW = DEFAULT_DW
);
    logic                  in_valid;
    logic [DW-1:0]         din;
    logic                  in_ready;
    logic [LANES-1:0]      ren;
    logic [LANES*DW-1:0]   dout;
    logic [LANES-1:0]      out_valid;
    logic [LANES-1:0]      error;
    lane_idx_t             wr_lane;

    modport master (
        output in_valid, din, ren,
        input  in_ready, dout, out_valid, error, wr_lane
    );

    modport slave (
        input  in_valid, din, ren,
        output in_ready, dout, out_valid, error, wr_lane
    );
endinterface

// File: rtl/dispatch_lane_fifo.sv
// rtl/dispatch_lane_fifo.sv - one lane FIFO with registered read data, valid and empty-read error
module dispatch_lane_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] dout,
    output logic          out_valid,
    output logic          error
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          out_valid_q, out_valid_d;
    logic          error_q, error_d;
    logic          do_wr, do_rd;

    // full/empty come from pre-edge state, so a read never frees room for a same-cycle write
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        out_valid_d = do_rd;
        error_d     = rd_en && empty;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            error_q     <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign error     = error_q;
endmodule

// File: rtl/rr_fifo_dispatcher.sv
// rtl/rr_fifo_dispatcher.sv - single stream to four lane FIFOs in round-robin order; RR_DISPATCH_SKIP_FULL_EN skips full lanes
module rr_fifo_dispatcher
    import rr_dispatch_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_fifo_dispatcher_if.slave bus
);
    lane_idx_t           wr_lane_q, wr_lane_d;
    lane_idx_t           target;
    logic                target_ok;
    logic                in_ready;
    logic                accept;
    logic [LANES-1:0]    full;
    logic [LANES-1:0]    lane_empty_unused;
    logic [LANES-1:0]    wr_en;
    logic [LANES*DW-1:0] dout_w;
    logic [LANES-1:0]    out_valid_w;
    logic [LANES-1:0]    error_w;

`ifdef RR_DISPATCH_SKIP_FULL_EN
    lane_idx_t cand;

    // Descending scan so the nearest non-full lane at or after the pointer wins
    always_comb begin
        target    = wr_lane_q;
        target_ok = 1'b0;
        cand      = wr_lane_q;
        for (int k = LANES - 1; k >= 0; k--) begin
            cand = wr_lane_q + lane_idx_t'(k);
            if (!full[cand]) begin
                target    = cand;
                target_ok = 1'b1;
            end
        end
    end
`else
    always_comb begin
        target    = wr_lane_q;
        target_ok = !full[wr_lane_q];
    end
`endif

    always_comb begin
        in_ready  = rst_n && target_ok;
        accept    = bus.in_valid && in_ready;
        wr_lane_d = accept ? lane_idx_t'(target + lane_idx_t'(1)) : wr_lane_q;
        wr_en     = '0;
        if (accept) begin
            wr_en[target] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_lane_q <= '0;
        end else begin
            wr_lane_q <= wr_lane_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dispatch_lane_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_en[i]),
            .wr_data   (bus.din),
            .rd_en     (bus.ren[i]),
            .full      (full[i]),
            .empty     (lane_empty_unused[i]),
            .dout      (dout_w[i*DW +: DW]),
            .out_valid (out_valid_w[i]),
            .error     (error_w[i])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.wr_lane   = wr_lane_q;
    assign bus.dout      = dout_w;
    assign bus.out_valid = out_valid_w;
    assign bus.error     = error_w;
endmodule

// File: tb/tb_rr_fifo_dispatcher.sv
// tb/tb_rr_fifo_dispatcher.sv - directed self-checking bench for rr_fifo_dispatcher
module tb_rr_fifo_dispatcher;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rr_fifo_dispatcher_if #(.DW(8)) bus ();

    rr_fifo_dispatcher #(.DW(8), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.din = '0;
        bus.ren = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.din = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic read(input logic [3:0] mask);
        bus.ren = mask;
        step();
        bus.ren = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.din = 8'h55;
        bus.ren = 4'b1111;
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        bus.ren = '0;
        checks++;
        if (bus.dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
        checks++;
        if (bus.out_valid !== 4'b0 || bus.error !== 4'b0) begin
            errors++; $display("FAIL reset_flags got ov=%b err=%b exp=0/0", bus.out_valid, bus.error);
        end
        checks++;
        if (bus.wr_lane !== 2'd0) begin errors++; $display("FAIL reset_wr_lane got=%0d exp=0", bus.wr_lane); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(8'h10 + 8'(i));
            checks++;
            if (bus.wr_lane !== 2'(i + 1)) begin
                errors++; $display("FAIL rot_wr_lane%0d got=%0d exp=%0d", i, bus.wr_lane, 2'(i + 1));
            end
        end
        read(4'b1111);
        checks++;
        if (bus.dout !== 32'h13121110) begin errors++; $display("FAIL rot_dout got=%h exp=13121110", bus.dout); end
        checks++;
        if (bus.out_valid !== 4'b1111 || bus.error !== 4'b0000) begin
            errors++; $display("FAIL rot_flags got ov=%b err=%b exp=1111/0000", bus.out_valid, bus.error);
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b0 || bus.dout !== 32'h13121110) begin
            errors++; $display("FAIL rot_hold got ov=%b dout=%h exp=0000/13121110", bus.out_valid, bus.dout);
        end
    endtask

    task automatic test_full_drain();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            bus.in_valid = 1'b1;
            bus.din = 8'(i);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got=%b exp=1", i, bus.in_ready); end
            step();
        end
        bus.din = 8'hEE;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.wr_lane !== 2'd0) begin
            errors++; $display("FAIL full_state got rdy=%b lane=%0d exp=0/0", bus.in_ready, bus.wr_lane);
        end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wr_lane !== 2'd0) begin errors++; $display("FAIL full_stall_lane got=%0d exp=0", bus.wr_lane); end
        for (int k = 0; k < 8; k++) begin
            read(4'b0100);
            checks++;
            if (bus.dout[23:16] !== 8'(2 + 4 * k) || bus.out_valid !== 4'b0100) begin
                errors++;
                $display("FAIL drain2_%0d got d=%h ov=%b exp=%h/0100", k, bus.dout[23:16], bus.out_valid, 8'(2 + 4 * k));
            end
        end
        read(4'b0100);
        checks++;
        if (bus.error !== 4'b0100 || bus.out_valid !== 4'b0000 || bus.dout[23:16] !== 8'h1E) begin
            errors++;
            $display("FAIL drain2_empty got err=%b ov=%b d=%h exp=0100/0000/1e", bus.error, bus.out_valid, bus.dout[23:16]);
        end
        checks++;
`ifdef RR_DISPATCH_SKIP_FULL_EN
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skip_ready got=%b exp=1", bus.in_ready); end
`else
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL strict_ready got=%b exp=0", bus.in_ready); end
`endif
    endtask

    task automatic test_empty_rw();
        do_reset();
        bus.in_valid = 1'b1;
        bus.din = 8'hAA;
        bus.ren = 4'b0001;
        step();
        bus.in_valid = 1'b0;
        bus.ren = '0;
        checks++;
        if (bus.error !== 4'b0001 || bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL empty_rw_err got err=%b ov=%b exp=0001/0000", bus.error, bus.out_valid);
        end
        read(4'b0001);
        checks++;
        if (bus.dout[7:0] !== 8'hAA || bus.out_valid !== 4'b0001 || bus.error !== 4'b0000) begin
            errors++;
            $display("FAIL empty_rw_read got d=%h ov=%b err=%b exp=aa/0001/0000", bus.dout[7:0], bus.out_valid, bus.error);
        end
    endtask

    task automatic test_skip_full();
        do_reset();
        for (int i = 0; i < 32; i++) push(8'(i));
        read(4'b0001);
        push(8'hC0);
        read(4'b0100);
        checks++;
        if (bus.wr_lane !== 2'd1) begin errors++; $display("FAIL skip_setup_lane got=%0d exp=1", bus.wr_lane); end
        bus.in_valid = 1'b1;
        bus.din = 8'hC1;
        #1;
        checks++;
`ifdef RR_DISPATCH_SKIP_FULL_EN
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skip_in_ready got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wr_lane !== 2'd3) begin errors++; $display("FAIL skip_wr_lane got=%0d exp=3", bus.wr_lane); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skip_all_full got=%b exp=0", bus.in_ready); end
`else
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL strict_in_ready got=%b exp=0", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wr_lane !== 2'd1) begin errors++; $display("FAIL strict_wr_lane got=%0d exp=1", bus.wr_lane); end
`endif
    endtask

    task automatic test_full_rw();
        logic [7:0] exp_l3 [8];
        do_reset();
        for (int i = 0; i < 32; i++) push(8'(i));
        read(4'b0111);
        for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
        checks++;
        if (bus.wr_lane !== 2'd3) begin errors++; $display("FAIL frw_setup_lane got=%0d exp=3", bus.wr_lane); end
        bus.in_valid = 1'b1;
        bus.din = 8'hB3;
        bus.ren = 4'b1000;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL frw_stall_ready got=%b exp=0", bus.in_ready); end
        step();
        bus.ren = '0;
        checks++;
        if (bus.out_valid !== 4'b1000 || bus.dout[31:24] !== 8'h03 || bus.wr_lane !== 2'd3) begin
            errors++;
            $display("FAIL frw_read got ov=%b d=%h lane=%0d exp=1000/03/3", bus.out_valid, bus.dout[31:24], bus.wr_lane);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL frw_room_ready got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.wr_lane !== 2'd0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL frw_accept got lane=%0d rdy=%b exp=0/0", bus.wr_lane, bus.in_ready);
        end
        for (int k = 0; k < 7; k++) exp_l3[k] = 8'(7 + 4 * k);
        exp_l3[7] = 8'hB3;
        for (int k = 0; k < 8; k++) begin
            read(4'b1000);
            checks++;
            if (bus.dout[31:24] !== exp_l3[k] || bus.out_valid !== 4'b1000) begin
                errors++;
                $display("FAIL frw_drain%0d got d=%h ov=%b exp=%h/1000", k, bus.dout[31:24], bus.out_valid, exp_l3[k]);
            end
        end
        read(4'b1000);
        checks++;
        if (bus.error !== 4'b1000) begin errors++; $display("FAIL frw_empty got err=%b exp=1000", bus.error); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        read(4'b1111);
        checks++;
        if (bus.dout !== 32'h23222120) begin errors++; $display("FAIL mid_pre_dout got=%h exp=23222120", bus.dout); end
        push(8'h30);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (bus.dout !== 32'h0 || bus.out_valid !== 4'b0 || bus.error !== 4'b0 || bus.wr_lane !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset got d=%h ov=%b err=%b lane=%0d exp=0/0/0/0", bus.dout, bus.out_valid, bus.error, bus.wr_lane);
        end
        read(4'b1111);
        checks++;
        if (bus.error !== 4'b1111 || bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL mid_empty got err=%b ov=%b exp=1111/0000", bus.error, bus.out_valid);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.din = '0;
        bus.ren = '0;
        test_reset();
        test_rotation();
        test_full_drain();
        test_empty_rw();
        test_skip_full();
        test_full_rw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
